network_host_if: RTL
====================

NETWORK_HOST_IF -- requirements
Module: network_host_if

Interface
REQ-001 The block SHALL take parameter INPUT_SIZE, default 2, giving the number of 32-bit input words loaded into the network.
REQ-002 The block SHALL take parameter OUTPUT_SIZE, default 1, giving the number of 32-bit result words returned to the host.
REQ-003 The block SHALL take parameter TIMEOUT, default 1024, giving the maximum cycles in WAIT before abort.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 n_rst  in  1  asynchronous, active-low reset.
REQ-006 host_data  in  8  host byte stream into the block.
REQ-007 host_valid  in  1  host_data valid.
REQ-008 host_ready  out  1  block accepts a byte.
REQ-009 res_data  out  8  result byte stream to the host.
REQ-010 res_valid  out  1  res_data valid.
REQ-011 res_ready  in  1  host accepts a result byte.
REQ-012 ctrl_to_net  out  8  drives the network controller control input; bit0 = start, bits 7:1 = 0.
REQ-013 ctrl_from_net  in  8  network controller control output; bit0 = finish, other bits ignored.
REQ-014 net_data_in  out  int [0:INPUT_SIZE-1]  input words to the network.
REQ-015 net_data_out  in  int [0:OUTPUT_SIZE-1]  result words from the network.
REQ-016 busy  out  1  high whenever state is not LOAD.
REQ-017 error  out  1  sticky timeout flag.

Function
REQ-018 The FSM SHALL have states LOAD, WAIT, DRAIN and SEND.
REQ-019 In LOAD, host_ready SHALL be 1; a byte SHALL be accepted on a rising edge with host_valid && host_ready; in all other states host_ready SHALL be 0 and host_valid SHALL be ignored.
REQ-020 Accepted byte k (0..4*INPUT_SIZE-1) SHALL be written to net_data_in[k/4] bits [8*(k%4)+7 : 8*(k%4)] (little-endian); other bits SHALL be unchanged.
REQ-021 On acceptance of byte 4*INPUT_SIZE-1, the FSM SHALL go to WAIT and the registered start bit SHALL be 1 from the next cycle.
REQ-022 net_data_in SHALL change only on accepted bytes and SHALL stay stable from WAIT until the next LOAD.
REQ-023 Acceptance of byte 0 SHALL clear error.
REQ-024 In WAIT, start SHALL be held at 1 and a 32-bit cycle counter, cleared on WAIT entry, SHALL increment each cycle.
REQ-025 In WAIT, when ctrl_from_net[0]=1, the block SHALL capture all of net_data_out into internal result registers, clear start, and go to DRAIN on the same edge.
REQ-026 In WAIT, when the counter reaches TIMEOUT-1 and finish=0, the block SHALL clear the result registers to 0, set error, clear start, and go to DRAIN.
REQ-027 If finish and timeout coincide, finish SHALL take priority and error SHALL stay unchanged.
REQ-028 In DRAIN, start SHALL be 0; the FSM SHALL move to SEND on the first cycle ctrl_from_net[0]=0.
REQ-029 In SEND, res_valid SHALL be 1 and res_data SHALL be result byte m, ordered word 0 first and little-endian within each word.
REQ-030 m SHALL advance on res_valid && res_ready; res_data SHALL hold while res_ready=0.
REQ-031 After byte 4*OUTPUT_SIZE-1 is accepted, the FSM SHALL return to LOAD with the byte counter at 0.
REQ-032 res_valid SHALL be 0 outside SEND.
REQ-033 start SHALL be a register output, glitch-free, and high only in WAIT.

Reset
REQ-034 While n_rst=0, the block SHALL hold: state=LOAD, host_ready=0, res_valid=0, res_data=0, ctrl_to_net=8'h00, net_data_in all 0, result registers 0, byte/result counters 0, cycle counter 0, busy=0, error=0.
REQ-035 Reset asserted mid-operation SHALL abort immediately, clear start asynchronously, and discard partial loads and results.

Verification
REQ-036 INPUT_SIZE=2: bytes 01,00,00,00,FF,FF,FF,FF -> net_data_in[0]=1, net_data_in[1]=-1; start=1 the cycle after byte 7; busy=1.
REQ-037 Controller model raises finish 257 cycles after start with net_data_out[0]=32'h12345678 -> start drops next edge; after finish falls, res_data sequence 78,56,34,12; then LOAD with host_ready=1.
REQ-038 res_ready held 0 for 5 cycles in SEND -> res_valid stays 1 and res_data stays 78; no byte is skipped.
REQ-039 TIMEOUT=16, finish never asserted -> start drops after 16 WAIT cycles; error=1; results 00,00,00,00; next byte 0 clears error.
REQ-040 n_rst pulsed low after 3 bytes and again during WAIT -> start=0 immediately; all outputs at REQ-034 values; the next 8-byte load behaves as in REQ-036.
REQ-041 host_valid=1 throughout WAIT/DRAIN/SEND with changing data -> net_data_in unchanged and no byte counted.

Source files
------------

// File: rtl/network_host_if.sv
// -----------------------------------------------------------------------------
// network_host_if
//
// Bridges a byte-wide host stream to a word-parallel network controller.
// The host loads 4*INPUT_SIZE bytes (little-endian per word) into
// net_data_in. The block then raises start and waits for the controller's
// finish. The controller's result words are captured and streamed back to
// the host as 4*OUTPUT_SIZE bytes, word 0 first and little-endian per word.
// If finish does not arrive within TIMEOUT cycles, the block returns zeroed
// results and sets a sticky error flag. The flag clears when the next
// load begins.
//
// Ports
//   clk            : single clock, rising edge
//   n_rst          : asynchronous active-low reset
//   host_data      : [7:0] host byte in
//   host_valid     : host_data valid
//   host_ready     : block accepts a byte (LOAD only)
//   res_data       : [7:0] result byte out
//   res_valid      : res_data valid (SEND only)
//   res_ready      : host accepts a result byte
//   ctrl_to_net    : [7:0] bit0 = start, bits 7:1 = 0
//   ctrl_from_net  : [7:0] bit0 = finish, other bits ignored
//   net_data_in    : INPUT_SIZE x 32-bit words to the network
//   net_data_out   : OUTPUT_SIZE x 32-bit words from the network
//   busy           : high whenever the FSM is not in LOAD
//   error          : sticky timeout flag
// -----------------------------------------------------------------------------
module network_host_if #(
    parameter int INPUT_SIZE  = 2,
    parameter int OUTPUT_SIZE = 1,
    parameter int TIMEOUT     = 1024
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [7:0]  host_data,
    input  logic        host_valid,
    output logic        host_ready,
    output logic [7:0]  res_data,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  ctrl_to_net,
    input  logic [7:0]  ctrl_from_net,
    output logic [31:0] net_data_in  [0:INPUT_SIZE-1],
    input  logic [31:0] net_data_out [0:OUTPUT_SIZE-1],
    output logic        busy,
    output logic        error
);

    localparam int IN_BYTES  = 4 * INPUT_SIZE;
    localparam int OUT_BYTES = 4 * OUTPUT_SIZE;
    localparam int BW        = $clog2(IN_BYTES);
    localparam int RW        = $clog2(OUT_BYTES);

    localparam logic [BW-1:0] IN_LAST  = BW'(IN_BYTES - 1);
    localparam logic [RW-1:0] OUT_LAST = RW'(OUT_BYTES - 1);
    localparam logic [31:0]   TO_LAST  = 32'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_SEND  = 2'd3
    } state_e;

    state_e                  state_q;
    logic [BW-1:0]           byte_cnt_q;
    logic [RW-1:0]           res_cnt_q;
    logic [31:0]             cyc_cnt_q;
    logic                    start_q;
    logic                    error_q;
    logic                    busy_q;
    logic                    host_ready_q;
    logic                    res_valid_q;
    logic [7:0]              res_data_q;
    // Words are stored flat so byte k sits at bits [8k+7:8k], which is
    // exactly the little-endian word-0-first byte order on both streams.
    logic [32*INPUT_SIZE-1:0]  in_flat_q;
    logic [32*OUTPUT_SIZE-1:0] res_flat_q;

    logic                    finish_s;
    logic                    accept_s;
    logic [RW-1:0]           res_nxt_s;
    logic                    unused_ctrl_s;

    assign finish_s      = ctrl_from_net[0];
    assign unused_ctrl_s = ^ctrl_from_net[7:1];
    assign accept_s      = host_valid && host_ready_q;
    assign res_nxt_s     = res_cnt_q + RW'(1);

    // Output wiring straight from registers.
    assign host_ready  = host_ready_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign ctrl_to_net = {7'b000_0000, start_q};
    assign busy        = busy_q;
    assign error       = error_q;

    // Present the flat input buffer as the word array seen by the network.
    for (genvar w = 0; w < INPUT_SIZE; w++) begin : g_net_in
        assign net_data_in[w] = in_flat_q[32*w +: 32];
    end

    // Main FSM with all datapath registers and registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= ST_LOAD;
            byte_cnt_q   <= '0;
            res_cnt_q    <= '0;
            cyc_cnt_q    <= 32'd0;
            start_q      <= 1'b0;
            error_q      <= 1'b0;
            busy_q       <= 1'b0;
            host_ready_q <= 1'b0;
            res_valid_q  <= 1'b0;
            res_data_q   <= 8'h00;
            in_flat_q    <= '0;
            res_flat_q   <= '0;
        end else begin
            unique case (state_q)
                ST_LOAD: begin
                    host_ready_q <= 1'b1;
                    busy_q       <= 1'b0;
                    if (accept_s) begin
                        in_flat_q[{byte_cnt_q, 3'b000} +: 8] <= host_data;
                        if (byte_cnt_q == '0) begin
                            error_q <= 1'b0;
                        end
                        if (byte_cnt_q == IN_LAST) begin
                            byte_cnt_q   <= '0;
                            cyc_cnt_q    <= 32'd0;
                            start_q      <= 1'b1;
                            busy_q       <= 1'b1;
                            host_ready_q <= 1'b0;
                            state_q      <= ST_WAIT;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + BW'(1);
                        end
                    end
                end
                ST_WAIT: begin
                    // Finish is tested first so it wins over a coincident timeout.
                    if (finish_s) begin
                        for (int w = 0; w < OUTPUT_SIZE; w++) begin
                            res_flat_q[32*w +: 32] <= net_data_out[w];
                        end
                        start_q <= 1'b0;
                        state_q <= ST_DRAIN;
                    end else if (cyc_cnt_q == TO_LAST) begin
                        res_flat_q <= '0;
                        error_q    <= 1'b1;
                        start_q    <= 1'b0;
                        state_q    <= ST_DRAIN;
                    end else begin
                        cyc_cnt_q <= cyc_cnt_q + 32'd1;
                    end
                end
                ST_DRAIN: begin
                    // Wait for the controller to drop finish before streaming,
                    // so a lingering finish cannot be mistaken for a new one.
                    if (!finish_s) begin
                        res_cnt_q   <= '0;
                        res_data_q  <= res_flat_q[7:0];
                        res_valid_q <= 1'b1;
                        state_q     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (res_valid_q && res_ready) begin
                        if (res_cnt_q == OUT_LAST) begin
                            res_cnt_q    <= '0;
                            res_valid_q  <= 1'b0;
                            res_data_q   <= 8'h00;
                            host_ready_q <= 1'b1;
                            busy_q       <= 1'b0;
                            state_q      <= ST_LOAD;
                        end else begin
                            res_cnt_q  <= res_nxt_s;
                            res_data_q <= res_flat_q[{res_nxt_s, 3'b000} +: 8];
                        end
                    end
                end
                default: begin
                    state_q      <= ST_LOAD;
                    start_q      <= 1'b0;
                    res_valid_q  <= 1'b0;
                    host_ready_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

endmodule
